// File: rtl/regfile_2r1w_32x32_ctl_pkg.sv
// Shared constants and types for the 32x32 2R1W register-file front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: entry count, data/address widths, big-endian-indexed address/data
// types matching the macro pinout, and the INIT/RUN state encoding.
package regfile_2r1w_32x32_ctl_pkg;

  localparam int N_ENTRIES = 32;
  localparam int DAT_W     = 32;
  localparam int ADR_W     = 5;

  // Bit 0 is the MSB on every macro-facing bus.
  typedef logic [0:ADR_W-1] adr_t;
  typedef logic [0:DAT_W-1] dat_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam adr_t LAST_ADR = adr_t'(N_ENTRIES - 1);

endpackage

// File: rtl/regfile_predec_5b.sv
// Address predecoder for one macro port: en + 5-bit address -> ten select lines.
// Latency: combinational.
// Backpressure: none; a disabled port drives all ten lines low.
// Ports: en, adr[0:4] (bit 0 = MSB) in; c_na0/c_a0, the four a1/a2 one-hot
// terms, na3/a3 and na4/a4 out.
module regfile_predec_5b
  import regfile_2r1w_32x32_ctl_pkg::*;
(
  input  logic en,
  input  adr_t adr,
  output logic c_na0,
  output logic c_a0,
  output logic na1_na2,
  output logic na1_a2,
  output logic a1_na2,
  output logic a1_a2,
  output logic na3,
  output logic a3,
  output logic na4,
  output logic a4
);

  // The port enable is folded into every group so an idle port selects nothing.
  assign c_na0   = en & ~adr[0];
  assign c_a0    = en &  adr[0];
  assign na1_na2 = en & ~adr[1] & ~adr[2];
  assign na1_a2  = en & ~adr[1] &  adr[2];
  assign a1_na2  = en &  adr[1] & ~adr[2];
  assign a1_a2   = en &  adr[1] &  adr[2];
  assign na3     = en & ~adr[3];
  assign a3      = en &  adr[3];
  assign na4     = en & ~adr[4];
  assign a4      = en &  adr[4];

endmodule

// File: rtl/regfile_2r1w_32x32_ctl.sv
// Front-end controller for the 32x32 2R1W register-file macro: registers
// requests, predecodes addresses, captures read data, clears the array after reset.
// Latency: read data valid two edges after the request is presented; write
// reaches the macro in the cycle after it is sampled.
// Backpressure: ready is low during the 32-cycle post-reset clear; requests
// presented while ready is low are dropped.
// Ports: clk, reset (async, active-high); rd0/rd1/wr0 en+adr in; wr0_dat in;
// rd*_q/rd*_q_val out; 10 predecode lines per port, wr0_arr_dat out; rd*_arr_dat in.
// Option: define REGFILE_BYPASS_EN to forward same-stage write data to colliding reads.
module regfile_2r1w_32x32_ctl
  import regfile_2r1w_32x32_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        rd0_en,
  input  logic [0:4]  rd0_adr,
  input  logic        rd1_en,
  input  logic [0:4]  rd1_adr,
  input  logic        wr0_en,
  input  logic [0:4]  wr0_adr,
  input  logic [0:31] wr0_dat,
  output logic [0:31] rd0_q,
  output logic [0:31] rd1_q,
  output logic        rd0_q_val,
  output logic        rd1_q_val,
  output logic        rd0_c_na0,
  output logic        rd0_c_a0,
  output logic        rd0_na1_na2,
  output logic        rd0_na1_a2,
  output logic        rd0_a1_na2,
  output logic        rd0_a1_a2,
  output logic        rd0_na3,
  output logic        rd0_a3,
  output logic        rd0_na4,
  output logic        rd0_a4,
  output logic        rd1_c_na0,
  output logic        rd1_c_a0,
  output logic        rd1_na1_na2,
  output logic        rd1_na1_a2,
  output logic        rd1_a1_na2,
  output logic        rd1_a1_a2,
  output logic        rd1_na3,
  output logic        rd1_a3,
  output logic        rd1_na4,
  output logic        rd1_a4,
  output logic        wr0_c_na0,
  output logic        wr0_c_a0,
  output logic        wr0_na1_na2,
  output logic        wr0_na1_a2,
  output logic        wr0_a1_na2,
  output logic        wr0_a1_a2,
  output logic        wr0_na3,
  output logic        wr0_a3,
  output logic        wr0_na4,
  output logic        wr0_a4,
  output logic [0:31] wr0_arr_dat,
  input  logic [0:31] rd0_arr_dat,
  input  logic [0:31] rd1_arr_dat
);

  state_t state;
  state_t state_nxt;
  adr_t   init_cnt;
  logic   init_last;

  // Stage-1 request registers: these drive the predecoders directly.
  logic   s_rd0_en;
  logic   s_rd1_en;
  logic   s_wr0_en;
  adr_t   s_rd0_adr;
  adr_t   s_rd1_adr;
  adr_t   s_wr0_adr;
  dat_t   s_wr0_dat;

  dat_t   rd0_cap;
  dat_t   rd1_cap;

  // The clear sequence ends once the write to the last entry is on the macro pins.
  assign init_last = (state == INIT) && s_wr0_en && (s_wr0_adr == LAST_ADR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready = (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         init_cnt <= '0;
    else if (state == INIT && !init_last) init_cnt <= init_cnt + 5'd1;
  end

  // In INIT the write stage is owned by the clear sequence and user requests
  // are discarded; in RUN every port is registered straight from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rd0_en  <= 1'b0;
      s_rd1_en  <= 1'b0;
      s_wr0_en  <= 1'b0;
      s_rd0_adr <= '0;
      s_rd1_adr <= '0;
      s_wr0_adr <= '0;
      s_wr0_dat <= '0;
    end else if (state == INIT) begin
      s_rd0_en  <= 1'b0;
      s_rd1_en  <= 1'b0;
      s_wr0_en  <= ~init_last;
      s_rd0_adr <= '0;
      s_rd1_adr <= '0;
      s_wr0_adr <= init_cnt;
      s_wr0_dat <= '0;
    end else begin
      s_rd0_en  <= rd0_en;
      s_rd1_en  <= rd1_en;
      s_wr0_en  <= wr0_en;
      s_rd0_adr <= rd0_adr;
      s_rd1_adr <= rd1_adr;
      s_wr0_adr <= wr0_adr;
      s_wr0_dat <= wr0_dat;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A read of the entry being written this cycle sees the new data.
  assign rd0_cap = (s_rd0_en && s_wr0_en && (s_rd0_adr == s_wr0_adr)) ? s_wr0_dat : rd0_arr_dat;
  assign rd1_cap = (s_rd1_en && s_wr0_en && (s_rd1_adr == s_wr0_adr)) ? s_wr0_dat : rd1_arr_dat;
`else
  assign rd0_cap = rd0_arr_dat;
  assign rd1_cap = rd1_arr_dat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd0_q     <= '0;
      rd1_q     <= '0;
      rd0_q_val <= 1'b0;
      rd1_q_val <= 1'b0;
    end else begin
      rd0_q_val <= s_rd0_en;
      rd1_q_val <= s_rd1_en;
      if (s_rd0_en) rd0_q <= rd0_cap;
      if (s_rd1_en) rd1_q <= rd1_cap;
    end
  end

  assign wr0_arr_dat = s_wr0_en ? s_wr0_dat : '0;

  regfile_predec_5b u_predec_rd0 (
    .en(s_rd0_en), .adr(s_rd0_adr),
    .c_na0(rd0_c_na0), .c_a0(rd0_c_a0),
    .na1_na2(rd0_na1_na2), .na1_a2(rd0_na1_a2), .a1_na2(rd0_a1_na2), .a1_a2(rd0_a1_a2),
    .na3(rd0_na3), .a3(rd0_a3), .na4(rd0_na4), .a4(rd0_a4)
  );

  regfile_predec_5b u_predec_rd1 (
    .en(s_rd1_en), .adr(s_rd1_adr),
    .c_na0(rd1_c_na0), .c_a0(rd1_c_a0),
    .na1_na2(rd1_na1_na2), .na1_a2(rd1_na1_a2), .a1_na2(rd1_a1_na2), .a1_a2(rd1_a1_a2),
    .na3(rd1_na3), .a3(rd1_a3), .na4(rd1_na4), .a4(rd1_a4)
  );

  regfile_predec_5b u_predec_wr0 (
    .en(s_wr0_en), .adr(s_wr0_adr),
    .c_na0(wr0_c_na0), .c_a0(wr0_c_a0),
    .na1_na2(wr0_na1_na2), .na1_a2(wr0_na1_a2), .a1_na2(wr0_a1_na2), .a1_a2(wr0_a1_a2),
    .na3(wr0_na3), .a3(wr0_a3), .na4(wr0_na4), .a4(wr0_a4)
  );

endmodule

// File: tb/tb_regfile_2r1w_32x32_ctl.sv
// Bench for regfile_2r1w_32x32_ctl: a behavioural macro array answers the
// predecoded reads, a transaction-level model predicts every output each cycle,
// and directed scenarios add literal expectations.
module tb_regfile_2r1w_32x32_ctl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ready;
  logic        rd0_en, rd1_en, wr0_en;
  logic [0:4]  rd0_adr, rd1_adr, wr0_adr;
  logic [0:31] wr0_dat, rd0_q, rd1_q, wr0_arr_dat, rd0_arr_dat, rd1_arr_dat;
  logic        rd0_q_val, rd1_q_val;
  logic rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4;
  logic rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4;
  logic wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4;

  regfile_2r1w_32x32_ctl dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd0_en(rd0_en), .rd0_adr(rd0_adr), .rd1_en(rd1_en), .rd1_adr(rd1_adr),
    .wr0_en(wr0_en), .wr0_adr(wr0_adr), .wr0_dat(wr0_dat),
    .rd0_q(rd0_q), .rd1_q(rd1_q), .rd0_q_val(rd0_q_val), .rd1_q_val(rd1_q_val),
    .rd0_c_na0(rd0_c_na0), .rd0_c_a0(rd0_c_a0), .rd0_na1_na2(rd0_na1_na2), .rd0_na1_a2(rd0_na1_a2),
    .rd0_a1_na2(rd0_a1_na2), .rd0_a1_a2(rd0_a1_a2), .rd0_na3(rd0_na3), .rd0_a3(rd0_a3),
    .rd0_na4(rd0_na4), .rd0_a4(rd0_a4),
    .rd1_c_na0(rd1_c_na0), .rd1_c_a0(rd1_c_a0), .rd1_na1_na2(rd1_na1_na2), .rd1_na1_a2(rd1_na1_a2),
    .rd1_a1_na2(rd1_a1_na2), .rd1_a1_a2(rd1_a1_a2), .rd1_na3(rd1_na3), .rd1_a3(rd1_a3),
    .rd1_na4(rd1_na4), .rd1_a4(rd1_a4),
    .wr0_c_na0(wr0_c_na0), .wr0_c_a0(wr0_c_a0), .wr0_na1_na2(wr0_na1_na2), .wr0_na1_a2(wr0_na1_a2),
    .wr0_a1_na2(wr0_a1_na2), .wr0_a1_a2(wr0_a1_a2), .wr0_na3(wr0_na3), .wr0_a3(wr0_a3),
    .wr0_na4(wr0_na4), .wr0_a4(wr0_a4),
    .wr0_arr_dat(wr0_arr_dat), .rd0_arr_dat(rd0_arr_dat), .rd1_arr_dat(rd1_arr_dat)
  );

  // Predecode lines packed as {na0,a0,na1_na2,na1_a2,a1_na2,a1_a2,na3,a3,na4,a4}.
  logic [9:0] rd0_pd, rd1_pd, wr0_pd;
  assign rd0_pd = {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2, rd0_na3, rd0_a3, rd0_na4, rd0_a4};
  assign rd1_pd = {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2, rd1_na3, rd1_a3, rd1_na4, rd1_a4};
  assign wr0_pd = {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2, wr0_na3, wr0_a3, wr0_na4, wr0_a4};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ten lines for an address, from its numeric value.
  function automatic logic [9:0] pd_exp(input logic en, input int a);
    logic [9:0] v;
    v = '0;
    if (en) begin
      if (a >= 16) v[8] = 1'b1; else v[9] = 1'b1;
      v[7 - ((a / 4) % 4)] = 1'b1;
      if ((a / 2) % 2 == 1) v[2] = 1'b1; else v[3] = 1'b1;
      if (a % 2 == 1) v[0] = 1'b1; else v[1] = 1'b1;
    end
    return v;
  endfunction

  function automatic int dec(input logic [9:0] pd);
    int g;
    g = pd[7] ? 0 : pd[6] ? 1 : pd[5] ? 2 : 3;
    return (pd[8] ? 16 : 0) + g * 4 + (pd[2] ? 2 : 0) + (pd[0] ? 1 : 0);
  endfunction

  // Behavioural macro: writes commit at the clock edge, reads return current contents.
  logic [31:0] macro_mem [32];
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) macro_mem[i] <= 32'hA5A5_0000 | 32'(i);
      seeded <= 1'b1;
    end else if (wr0_pd != 10'd0) begin
      macro_mem[dec(wr0_pd)] <= wr0_arr_dat;
    end
  end
  always_comb begin
    rd0_arr_dat = 32'hBAD0_BAD0;
    rd1_arr_dat = 32'hBAD0_BAD0;
    if (rd0_pd != 10'd0) rd0_arr_dat = macro_mem[dec(rd0_pd)];
    if (rd1_pd != 10'd0) rd1_arr_dat = macro_mem[dec(rd1_pd)];
  end

  // Transaction model: mdl_cyc counts edges since reset; edges 1..32 clear the
  // array, ready from edge 33, requests presented while ready are accepted.
  int          mdl_cyc = 0;
  logic        p_rd_en [2];
  int          p_rd_adr [2];
  logic        p_wr_en;
  int          p_wr_adr;
  logic [31:0] p_wr_dat;
  logic [31:0] exp_q [2];
  logic        exp_val [2];
  logic        exp_known [2];
  logic [31:0] mdl_mem [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_cyc  <= 0;
      p_wr_en  <= 1'b0;
      p_wr_adr <= 0;
      p_wr_dat <= '0;
      for (int i = 0; i < 2; i++) begin
        p_rd_en[i] <= 1'b0; p_rd_adr[i] <= 0;
        exp_q[i] <= '0; exp_val[i] <= 1'b0; exp_known[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_val[i] <= p_rd_en[i];
        if (p_rd_en[i]) begin
          if (p_wr_en && p_wr_adr == p_rd_adr[i]) begin
`ifdef REGFILE_BYPASS_EN
            exp_q[i] <= p_wr_dat; exp_known[i] <= 1'b1;
`else
            exp_known[i] <= 1'b0;
`endif
          end else begin
            exp_q[i] <= mdl_mem[p_rd_adr[i]]; exp_known[i] <= 1'b1;
          end
        end
      end
      if (p_wr_en) mdl_mem[p_wr_adr] <= p_wr_dat;
      mdl_cyc <= mdl_cyc + 1;
      if (mdl_cyc < 32) begin
        p_wr_en <= 1'b1; p_wr_adr <= mdl_cyc; p_wr_dat <= '0;
        p_rd_en[0] <= 1'b0; p_rd_en[1] <= 1'b0;
      end else if (mdl_cyc >= 33) begin
        p_wr_en <= wr0_en; p_wr_adr <= int'(wr0_adr); p_wr_dat <= wr0_dat;
        p_rd_en[0] <= rd0_en; p_rd_adr[0] <= int'(rd0_adr);
        p_rd_en[1] <= rd1_en; p_rd_adr[1] <= int'(rd1_adr);
      end else begin
        p_wr_en <= 1'b0; p_rd_en[0] <= 1'b0; p_rd_en[1] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(mdl_cyc >= 33));
    check("rd0_predec", 32'(rd0_pd), 32'(pd_exp(p_rd_en[0], p_rd_adr[0])));
    check("rd1_predec", 32'(rd1_pd), 32'(pd_exp(p_rd_en[1], p_rd_adr[1])));
    check("wr0_predec", 32'(wr0_pd), 32'(pd_exp(p_wr_en, p_wr_adr)));
    check("wr0_arr_dat", wr0_arr_dat, p_wr_en ? p_wr_dat : 32'h0);
    check("rd0_q_val", 32'(rd0_q_val), 32'(exp_val[0]));
    check("rd1_q_val", 32'(rd1_q_val), 32'(exp_val[1]));
    if (exp_known[0]) check("rd0_q", rd0_q, exp_q[0]);
    if (exp_known[1]) check("rd1_q", rd1_q, exp_q[1]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rd0_en = 1'b0; rd1_en = 1'b0; wr0_en = 1'b0;
    rd0_adr = '0; rd1_adr = '0; wr0_adr = '0; wr0_dat = '0;
  endtask

  task automatic init_sequence(input string tag);
    int low;
    low = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (!ready) low++;
      check({tag, "_wr_en"}, 32'(wr0_pd != 10'd0), 32'd1);
      check({tag, "_wr_adr"}, 32'(dec(wr0_pd)), 32'(k));
      check({tag, "_wr_dat"}, wr0_arr_dat, 32'h0);
    end
    check({tag, "_ready_low_cycles"}, 32'(low), 32'd32);
    tick();
    check({tag, "_ready_rise"}, 32'(ready), 32'd1);
  endtask

  initial begin
    idle();
    repeat (3) tick();
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rd0_q", rd0_q, 32'h0);
    check("reset_wr0_pd", 32'(wr0_pd), 32'd0);
    reset = 1'b0;
    init_sequence("init");

    // Read of a cleared entry.
    rd0_en = 1'b1; rd0_adr = 5'd17;
    tick(); idle();
    tick();
    check("rd17_val", 32'(rd0_q_val), 32'd1);
    check("rd17_q", rd0_q, 32'h0);

    // Write then read two cycles later.
    wr0_en = 1'b1; wr0_adr = 5'd5; wr0_dat = 32'hDEADBEEF;
    tick(); idle();
    tick();
    rd0_en = 1'b1; rd0_adr = 5'd5;
    tick(); idle();
    tick();
    check("rd5_val", 32'(rd0_q_val), 32'd1);
    check("rd5_q", rd0_q, 32'hDEADBEEF);
    tick();
    check("rd5_val_pulse", 32'(rd0_q_val), 32'd0);
    check("rd5_q_hold", rd0_q, 32'hDEADBEEF);

    // Predecode of 5'b10110 on rd1, then disabled.
    rd1_en = 1'b1; rd1_adr = 5'b10110;
    tick(); idle();
    check("rd1_predec_10110", 32'(rd1_pd), 32'(10'b0101000110));
    tick();
    check("rd1_predec_off", 32'(rd1_pd), 32'd0);

    // Back-to-back writes, then a colliding read on rd0 and a neighbour read on rd1.
    wr0_en = 1'b1; wr0_adr = 5'd8; wr0_dat = 32'h88888888;
    tick();
    wr0_adr = 5'd9; wr0_dat = 32'h12345678;
    rd0_en = 1'b1; rd0_adr = 5'd9;
    rd1_en = 1'b1; rd1_adr = 5'd8;
    tick(); idle();
    tick();
    check("coll_rd1_q", rd1_q, 32'h88888888);
    check("coll_rd0_val", 32'(rd0_q_val), 32'd1);
`ifdef REGFILE_BYPASS_EN
    check("coll_rd0_bypass", rd0_q, 32'h12345678);
`endif
    rd0_en = 1'b1; rd0_adr = 5'd9;
    tick(); idle();
    tick();
    check("rd9_after", rd0_q, 32'h12345678);

    // Reset while a write and a read are on the macro pins.
    wr0_en = 1'b1; wr0_adr = 5'd20; wr0_dat = 32'hCAFEF00D;
    rd0_en = 1'b1; rd0_adr = 5'd5;
    tick();
    check("mid_wr_adr", 32'(dec(wr0_pd)), 32'd20);
    #1 reset = 1'b1;
    #1;
    check("mid_wr_pd", 32'(wr0_pd), 32'd0);
    check("mid_ready", 32'(ready), 32'd0);
    check("mid_rd0_val", 32'(rd0_q_val), 32'd0);
    check("mid_rd0_q", rd0_q, 32'h0);
    check("mid_arr_dat", wr0_arr_dat, 32'h0);
    // Request during reset and init must be ignored.
    wr0_en = 1'b1; wr0_adr = 5'd3; wr0_dat = 32'hFFFFFFFF;
    rd0_en = 1'b0;
    tick();
    check("mid_no_macro_write", macro_mem[20], 32'h0);
    tick();
    reset = 1'b0;
    init_sequence("reinit");
    idle();

    rd0_en = 1'b1; rd0_adr = 5'd3;
    rd1_en = 1'b1; rd1_adr = 5'd20;
    tick(); idle();
    tick();
    check("init_req_ignored", rd0_q, 32'h0);
    check("dropped_write", rd1_q, 32'h0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
